// File: rtl/mem_pkg.sv
// Shared types and encodings for the parameterised memory with clear sweep.
package mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    function automatic int unsigned mem_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/param_mem_if.sv
// Request/response bundle between a requester and param_mem.
interface param_mem_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              clear;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              err;

    modport master (
        output read, write, addr, data_in, clear,
        input  data_out, rd_valid, busy, err
    );

    modport slave (
        input  read, write, addr, data_in, clear,
        output data_out, rd_valid, busy, err
    );
endinterface

// File: rtl/param_mem_array.sv
// Single-port synchronous storage: write enable, registered read (read-old), no reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int unsigned DEPTH = mem_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/param_mem.sv
// Memory with one-cycle registered read, selectable read-during-write policy and a
// one-word-per-cycle clear sweep that also runs after reset.
module param_mem
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RDW_MODE = RDW_OLD
) (
    input  logic           clk,
    input  logic           rst,
    param_mem_if.slave     bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_sweep, w_sweep_nxt;
    logic              r_rd_valid;
    logic              r_err;
    logic              r_sel_byp;
    logic [DATA_W-1:0] r_byp_data;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_reject;
    logic              w_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [DATA_W-1:0] w_arr_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_rd_acc    = 1'b0;
        w_wr_acc    = 1'b0;
        w_reject    = 1'b0;
        w_we        = 1'b0;
        w_arr_addr  = bus.addr;
        w_arr_wdata = bus.data_in;
        unique case (r_state)
            IDLE: begin
                if (bus.clear) begin
                    w_state_nxt = CLEAR;
                    w_sweep_nxt = '0;
                    w_reject    = bus.read | bus.write;
                end else begin
                    w_rd_acc = bus.read;
                    w_wr_acc = bus.write;
                    w_we     = bus.write;
                end
            end
            CLEAR: begin
                w_we        = 1'b1;
                w_arr_addr  = r_sweep;
                w_arr_wdata = '0;
                w_reject    = bus.read | bus.write;
                // Terminal compare: the counter parks on the last word instead of wrapping.
                if (r_sweep == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_sweep_nxt = r_sweep + 1'b1;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Bypass select resets high so data_out reads zero before any read lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_sweep    <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_sel_byp  <= 1'b1;
            r_byp_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sweep    <= w_sweep_nxt;
            r_rd_valid <= w_rd_acc;
            r_err      <= w_reject;
            if (w_rd_acc) begin
                r_sel_byp  <= (RDW_MODE == RDW_NEW) && w_wr_acc;
                r_byp_data <= bus.data_in;
            end
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_rd_acc),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign bus.data_out = r_sel_byp ? r_byp_data : w_arr_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign bus.err      = r_err;
    assign bus.busy     = (r_state == CLEAR);
endmodule
